// File: rtl/lutram_wr_sched.sv
// lutram_wr_sched: shares the single synchronous write port of a LUTRAM
// (RAM64X1D/RAM128X1D style) between two requesters with round-robin
// arbitration, and sweeps the whole memory to a fill value after reset
// and on request. WA/WD/WE are registered and drive the RAM pins directly.
module lutram_wr_sched #(
    parameter int unsigned ABITS          = 6,
    parameter int unsigned DBITS          = 1,
    parameter bit          CLEAR_VAL      = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR_REQ,
    output logic             CLR_BUSY,
    input  logic             A_VALID,
    input  logic [ABITS-1:0] A_ADDR,
    input  logic [DBITS-1:0] A_DATA,
    output logic             A_READY,
    input  logic             B_VALID,
    input  logic [ABITS-1:0] B_ADDR,
    input  logic [DBITS-1:0] B_DATA,
    output logic             B_READY,
    output logic [ABITS-1:0] WA,
    output logic [DBITS-1:0] WD,
    output logic             WE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN
    } state_t;

    localparam logic [ABITS-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_next;
    logic [ABITS-1:0]   r_cnt;
    logic               r_ptr;      // 0 = A favoured on contention, 1 = B
    logic [ABITS-1:0]   r_wa;
    logic [DBITS-1:0]   r_wd;
    logic               r_we;
    logic               w_run_ok;
    logic               w_a_grant;
    logic               w_b_grant;
    logic               w_busy;
    logic [DBITS-1:0]   w_fill;

    assign w_fill = {DBITS{CLEAR_VAL}};

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
            S_CLEAR: if (r_cnt == CNT_MAX) w_next = S_RUN;
            S_RUN:   if (CLR_REQ) w_next = S_CLEAR;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs: round-robin grants (RUN only, suppressed by CLR_REQ) and busy flag
    always_comb begin
        w_run_ok  = (r_state == S_RUN) && !CLR_REQ;
        w_a_grant = w_run_ok && A_VALID && (!B_VALID || !r_ptr);
        w_b_grant = w_run_ok && B_VALID && (!A_VALID || r_ptr);
        w_busy    = (r_state == S_CLEAR);
    end

    // Sweep counter; it mirrors the address currently shown on WA during CLEAR
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_cnt <= r_cnt + ABITS'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Round-robin pointer: after any grant the other side is favoured
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= 1'b0;
        end else if (w_a_grant) begin
            r_ptr <= 1'b1;
        end else if (w_b_grant) begin
            r_ptr <= 1'b0;
        end
    end

    // Write-port registers; loaded from the next state so WE coincides with CLR_BUSY
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_next == S_CLEAR) begin
            r_we <= 1'b1;
            r_wa <= (r_state == S_CLEAR) ? (r_cnt + ABITS'(1)) : '0;
            r_wd <= w_fill;
        end else if (w_a_grant) begin
            r_we <= 1'b1;
            r_wa <= A_ADDR;
            r_wd <= A_DATA;
        end else if (w_b_grant) begin
            r_we <= 1'b1;
            r_wa <= B_ADDR;
            r_wd <= B_DATA;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign A_READY  = w_a_grant;
    assign B_READY  = w_b_grant;
    assign CLR_BUSY = w_busy;
    assign WA       = r_wa;
    assign WD       = r_wd;
    assign WE       = r_we;

endmodule

// File: tb/tb_lutram_wr_sched.sv
// Scoreboard bench for lutram_wr_sched: stimulus pushes expected RAM writes,
// negedge monitors pop and compare whenever WE is high.
module tb_lutram_wr_sched;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DUT 6: ABITS=6, CLEAR_ON_RESET=1
    logic       RST, CLR_REQ, CLR_BUSY;
    logic       A_VALID, A_READY, B_VALID, B_READY;
    logic [5:0] A_ADDR, B_ADDR, WA;
    logic       A_DATA, B_DATA, WD, WE;

    // DUT 7: ABITS=7, CLEAR_ON_RESET=0
    logic       RST7, CLR_BUSY7, A7_VALID, A7_READY, B7_READY;
    logic [6:0] A7_ADDR, WA7;
    logic       A7_DATA, WD7, WE7;

    lutram_wr_sched #(.ABITS(6), .DBITS(1), .CLEAR_VAL(1'b0), .CLEAR_ON_RESET(1'b1)) u_dut (
        .CLK(CLK), .RST(RST), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
        .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
        .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
        .WA(WA), .WD(WD), .WE(WE)
    );

    lutram_wr_sched #(.ABITS(7), .DBITS(1), .CLEAR_VAL(1'b0), .CLEAR_ON_RESET(1'b0)) u_dut7 (
        .CLK(CLK), .RST(RST7), .CLR_REQ(1'b0), .CLR_BUSY(CLR_BUSY7),
        .A_VALID(A7_VALID), .A_ADDR(A7_ADDR), .A_DATA(A7_DATA), .A_READY(A7_READY),
        .B_VALID(1'b0), .B_ADDR(7'd0), .B_DATA(1'b0), .B_READY(B7_READY),
        .WA(WA7), .WD(WD7), .WE(WE7)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic       data;
        logic       busy;
    } exp_t;

    exp_t sb6[$];
    exp_t sb7[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push6(input logic [5:0] a, input logic d, input logic busy);
        exp_t e;
        e.addr = {1'b0, a};
        e.data = d;
        e.busy = busy;
        sb6.push_back(e);
    endtask

    task automatic push_sweep6();
        for (int i = 0; i < 64; i++) push6(6'(i), 1'b0, 1'b1);
    endtask

    // One cycle on DUT 6: drive (called at posedge+1), check at negedge, return at posedge+1
    task automatic step(input logic av, input logic [5:0] aa, input logic ad,
                        input logic bv, input logic [5:0] ba, input logic bd,
                        input logic clr, input logic ea, input logic eb, input logic ebusy);
        A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
        CLR_REQ = clr;
        @(negedge CLK);
        chk("A_READY", 32'(A_READY), 32'(ea));
        chk("B_READY", 32'(B_READY), 32'(eb));
        chk("CLR_BUSY", 32'(CLR_BUSY), 32'(ebusy));
        if (ea) push6(aa, ad, 1'b0);
        if (eb) push6(ba, bd, 1'b0);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic ebusy);
        step(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, ebusy);
    endtask

    // Monitor DUT 6 write port
    always @(negedge CLK) begin
        if (WE) begin
            if (sb6.size() == 0) begin
                chk("unexpected write WE", 32'(WE), 32'd0);
            end else begin
                exp_t e;
                e = sb6.pop_front();
                chk("WA", 32'(WA), 32'(e.addr[5:0]));
                chk("WD", 32'(WD), 32'(e.data));
                chk("busy with WE", 32'(CLR_BUSY), 32'(e.busy));
            end
        end
    end

    // Monitor DUT 7 write port
    always @(negedge CLK) begin
        if (WE7) begin
            if (sb7.size() == 0) begin
                chk("unexpected write WE7", 32'(WE7), 32'd0);
            end else begin
                exp_t e;
                e = sb7.pop_front();
                chk("WA7", 32'(WA7), 32'(e.addr));
                chk("WD7", 32'(WD7), 32'(e.data));
                chk("busy7 with WE7", 32'(CLR_BUSY7), 32'(e.busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; CLR_REQ = 1'b0;
        A_VALID = 1'b0; A_ADDR = '0; A_DATA = 1'b0;
        B_VALID = 1'b0; B_ADDR = '0; B_DATA = 1'b0;
        RST7 = 1'b1; A7_VALID = 1'b0; A7_ADDR = '0; A7_DATA = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        chk("reset WE", 32'(WE), 32'd0);
        chk("reset WA", 32'(WA), 32'd0);
        chk("reset WD", 32'(WD), 32'd0);
        chk("reset CLR_BUSY", 32'(CLR_BUSY), 32'd0);

        // Release: IDLE one cycle, 64-cycle sweep, held A gets no READY until RUN
        push_sweep6();
        RST = 1'b0;
        step(1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++)
            step(1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // ptr -> B

        // B only for three back-to-back cycles
        step(1'b0, 6'd0, 1'b0, 1'b1, 6'd12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0); // ptr -> A
        step(1'b0, 6'd0, 1'b0, 1'b1, 6'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 6'd0, 1'b0, 1'b1, 6'd14, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Contention held 4 cycles: A, B, A, B
        step(1'b1, 6'd5, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd5, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 6'd5, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd5, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // ptr -> A
        idle(1'b0);
        idle(1'b0);
        chk("idle WE", 32'(WE), 32'd0);

        // CLR_REQ with A pending; second pulse mid-sweep is ignored
        push_sweep6();
        step(1'b1, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++)
            step(1'b1, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, (i == 10), 1'b0, 1'b0, 1'b1);
        step(1'b1, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // ptr -> B

        // Same address: A then B, both issued in order
        step(1'b1, 6'd2, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 6'd0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // Reset while the sweep shows WA=20
        push_sweep6();
        step(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b1);
        @(negedge CLK);
        chk("pre-reset WA", 32'(WA), 32'd20);
        #2;
        RST = 1'b1;
        #1;
        chk("async reset WE", 32'(WE), 32'd0);
        chk("async reset WA", 32'(WA), 32'd0);
        chk("async reset CLR_BUSY", 32'(CLR_BUSY), 32'd0);
        sb6.delete();
        push_sweep6();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(1'b0);
        for (int i = 0; i < 64; i++) idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("sb6 drained", 32'(sb6.size()), 32'd0);

        // DUT 7: no sweep, IDLE then RUN, write to address 127
        A7_VALID = 1'b1; A7_ADDR = 7'd127; A7_DATA = 1'b1;
        RST7 = 1'b0;
        @(negedge CLK);
        chk("A7_READY idle", 32'(A7_READY), 32'd0);
        chk("CLR_BUSY7 idle", 32'(CLR_BUSY7), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("A7_READY run", 32'(A7_READY), 32'd1);
        chk("CLR_BUSY7 run", 32'(CLR_BUSY7), 32'd0);
        if (A7_READY) sb7.push_back(exp_t'{addr: 7'd127, data: 1'b1, busy: 1'b0});
        else          sb7.push_back(exp_t'{addr: 7'd127, data: 1'b1, busy: 1'b0});
        @(posedge CLK);
        #1;
        A7_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("sb7 drained", 32'(sb7.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
